// File: rtl/updown_pkg.sv
// Shared mode encodings and helpers for the multi-mode up/down counter.
package updown_pkg;

    localparam logic [1:0] MODE_WRAP   = 2'd0;
    localparam logic [1:0] MODE_SAT    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    function automatic logic [31:0] clamp(
        input logic [31:0] v,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/updown_next_calc.sv
// Combinational next-value / next-direction logic for one enabled count cycle.
module updown_next_calc
    import updown_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned STEP_W  = 4,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 255
) (
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH:0]   s,
    input  logic             d,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_y,
    output logic             next_dir,
    output logic             ovf_n,
    output logic             unf_n
);

    localparam int unsigned AW = WIDTH + STEP_W + 1;
    localparam logic [AW-1:0] MIN_A = AW'(MIN_VAL);
    localparam logic [AW-1:0] MAX_A = AW'(MAX_VAL);

    logic [AW-1:0] ye;
    logic [AW-1:0] se;
    logic [AW-1:0] sum;
    logic [AW-1:0] lo_s;

    assign ye   = AW'(y);
    assign se   = AW'(s);
    assign sum  = ye + se;
    // Down-direction tests compare y against MIN+s so nothing goes negative.
    assign lo_s = MIN_A + se;

    always_comb begin
        next_y   = y;
        next_dir = d;
        ovf_n    = 1'b0;
        unf_n    = 1'b0;
        if (se != '0) begin
            case (mode)
                MODE_WRAP: begin
                    if (d) begin
                        if (sum > MAX_A) begin
                            next_y = WIDTH'(MIN_A + sum - MAX_A - AW'(1));
                            ovf_n  = 1'b1;
                        end else begin
                            next_y = WIDTH'(sum);
                        end
                    end else begin
                        if (ye < lo_s) begin
                            next_y = WIDTH'(MAX_A + AW'(1) + ye - MIN_A - se);
                            unf_n  = 1'b1;
                        end else begin
                            next_y = WIDTH'(ye - se);
                        end
                    end
                end
                MODE_SAT: begin
                    if (d) begin
                        if (sum >= MAX_A) begin
                            next_y = WIDTH'(MAX_A);
                            ovf_n  = (sum > MAX_A);
                        end else begin
                            next_y = WIDTH'(sum);
                        end
                    end else begin
                        if (ye <= lo_s) begin
                            next_y = WIDTH'(MIN_A);
                            unf_n  = (ye < lo_s);
                        end else begin
                            next_y = WIDTH'(ye - se);
                        end
                    end
                end
                MODE_BOUNCE: begin
                    if (d) begin
                        if (sum >= MAX_A) begin
                            next_y   = WIDTH'(MAX_A);
                            next_dir = 1'b0;
                            ovf_n    = 1'b1;
                        end else begin
                            next_y = WIDTH'(sum);
                        end
                    end else begin
                        if (ye <= lo_s) begin
                            next_y   = WIDTH'(MIN_A);
                            next_dir = 1'b1;
                            unf_n    = 1'b1;
                        end else begin
                            next_y = WIDTH'(ye - se);
                        end
                    end
                end
                default: begin
                    next_y   = y;
                    next_dir = d;
                end
            endcase
        end
    end

endmodule

// File: rtl/updown_counter_mm.sv
// Multi-mode windowed up/down counter: wrap, saturate, bounce and hold,
// with clamped synchronous load and registered boundary pulses.
module updown_counter_mm
    import updown_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MIN_VAL   = 0,
    parameter int unsigned MAX_VAL   = (1 << WIDTH) - 1,
    parameter int unsigned RESET_VAL = MIN_VAL,
    parameter int unsigned STEP_W    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              dir,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  y,
    output logic              cur_dir,
    output logic              tc,
    output logic              ovf,
    output logic              unf,
    output logic              load_clip
);

    localparam int unsigned AW = WIDTH + STEP_W + 1;
    localparam logic [AW-1:0]    RANGE_A = AW'(MAX_VAL - MIN_VAL + 1);
    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] y_q, y_d;
    logic             dir_q, dir_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             clip_q, clip_d;

    logic [AW-1:0]    step_a;
    logic [WIDTH:0]   s;
    logic             d;
    logic [WIDTH-1:0] calc_y;
    logic             calc_dir;
    logic             calc_ovf;
    logic             calc_unf;

    // Bounce and hold run on the stored direction; dir only matters at load.
    assign d      = (mode == MODE_BOUNCE || mode == MODE_HOLD) ? dir_q : dir;
    assign step_a = AW'(step);
    assign s      = (step_a > RANGE_A) ? (WIDTH+1)'(RANGE_A)
                                       : step_a[WIDTH:0];

    updown_next_calc #(
        .WIDTH   (WIDTH),
        .STEP_W  (STEP_W),
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL)
    ) u_calc (
        .y        (y_q),
        .s        (s),
        .d        (d),
        .mode     (mode),
        .next_y   (calc_y),
        .next_dir (calc_dir),
        .ovf_n    (calc_ovf),
        .unf_n    (calc_unf)
    );

    always_comb begin
        y_d    = y_q;
        dir_d  = dir_q;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        clip_d = 1'b0;
        if (load) begin
            y_d    = WIDTH'(clamp(32'(load_val), 32'(MIN_VAL), 32'(MAX_VAL)));
            dir_d  = dir;
            clip_d = (load_val < MIN_W) || (load_val > MAX_W);
        end else if (en) begin
            y_d   = calc_y;
            dir_d = calc_dir;
            ovf_d = calc_ovf;
            unf_d = calc_unf;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            y_q    <= WIDTH'(RESET_VAL);
            dir_q  <= 1'b1;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            clip_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            dir_q  <= dir_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            clip_q <= clip_d;
        end
    end

    assign y         = y_q;
    assign cur_dir   = dir_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign load_clip = clip_q;
    assign tc        = en && (mode != MODE_HOLD) &&
                       ((d && y_q == MAX_W) || (!d && y_q == MIN_W));

endmodule

// File: tb/tb_updown_counter_mm.sv
// Directed bench for updown_counter_mm with a 2..11 window on a 4-bit counter.
module tb_updown_counter_mm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic [3:0] step;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] y;
    logic       cur_dir;
    logic       tc;
    logic       ovf;
    logic       unf;
    logic       load_clip;

    int n_chk  = 0;
    int n_fail = 0;

    updown_counter_mm #(
        .WIDTH     (4),
        .MIN_VAL   (2),
        .MAX_VAL   (11),
        .RESET_VAL (2),
        .STEP_W    (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .dir       (dir),
        .mode      (mode),
        .step      (step),
        .load      (load),
        .load_val  (load_val),
        .y         (y),
        .cur_dir   (cur_dir),
        .tc        (tc),
        .ovf       (ovf),
        .unf       (unf),
        .load_clip (load_clip)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input int ey, input int ed,
                          input int eo, input int eu);
        chk({tag, ".y"}, int'(y), ey);
        chk({tag, ".dir"}, int'(cur_dir), ed);
        chk({tag, ".ovf"}, int'(ovf), eo);
        chk({tag, ".unf"}, int'(unf), eu);
    endtask

    task automatic do_load(input int v, input logic dv);
        load     = 1'b1;
        load_val = 4'(v);
        dir      = dv;
        tick();
        load     = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b1;
        en       = 1'b0;
        dir      = 1'b1;
        mode     = 2'd0;
        step     = 4'd0;
        load     = 1'b0;
        load_val = 4'd0;
        tick();
        tick();
        chk_st("rst", 2, 1, 0, 0);
        chk("rst.clip", int'(load_clip), 0);
        reset_n = 1'b0;
        tick();

        // async reset mid-cycle from y=7, cur_dir=0
        do_load(8, 1'b0);
        en = 1'b1; mode = 2'd0; step = 4'd1; dir = 1'b0;
        tick();
        chk_st("pre_rst", 7, 0, 0, 0);
        en = 1'b0;
        #3;
        reset_n = 1'b1;
        #1;
        chk_st("async_rst", 2, 1, 0, 0);
        tick();
        reset_n = 1'b0;
        tick();

        // wrap
        do_load(10, 1'b1);
        chk("wrap.load", int'(y), 10);
        en = 1'b1; mode = 2'd0; step = 4'd3; dir = 1'b1;
        tick();
        chk_st("wrap.up", 3, 1, 1, 0);
        dir = 1'b0;
        tick();
        chk_st("wrap.dn", 10, 0, 0, 1);
        en = 1'b0;
        tick();
        chk_st("wrap.idle", 10, 0, 0, 0);

        // saturate
        do_load(9, 1'b1);
        en = 1'b1; mode = 2'd1; step = 4'd4; dir = 1'b1;
        tick();
        chk_st("sat.up1", 11, 1, 1, 0);
        tick();
        chk_st("sat.up2", 11, 1, 1, 0);
        step = 4'd0;
        tick();
        chk_st("sat.s0", 11, 1, 0, 0);
        chk("sat.tc", int'(tc), 1);
        dir = 1'b0; step = 4'd15;
        tick();
        chk_st("sat.dn", 2, 0, 0, 1);

        // bounce; dir toggles are ignored
        en = 1'b0;
        do_load(9, 1'b1);
        en = 1'b1; mode = 2'd2; step = 4'd2; dir = 1'b1;
        tick();
        chk_st("bnc.11", 11, 0, 1, 0);
        dir = 1'b1;
        tick();
        chk_st("bnc.9", 9, 0, 0, 0);
        dir = 1'b0;
        tick();
        chk_st("bnc.7", 7, 0, 0, 0);
        dir = 1'b1;
        tick();
        chk_st("bnc.5", 5, 0, 0, 0);
        dir = 1'b0;
        tick();
        chk_st("bnc.3", 3, 0, 0, 0);
        dir = 1'b1;
        tick();
        chk_st("bnc.2", 2, 1, 0, 1);
        dir = 1'b0;
        tick();
        chk_st("bnc.4", 4, 1, 0, 0);

        // load clamping and priority over en
        en = 1'b0;
        do_load(14, 1'b1);
        chk("clip.hi.y", int'(y), 11);
        chk("clip.hi", int'(load_clip), 1);
        tick();
        chk("clip.pulse", int'(load_clip), 0);
        do_load(0, 1'b0);
        chk("clip.lo.y", int'(y), 2);
        chk("clip.lo", int'(load_clip), 1);
        en = 1'b1; mode = 2'd0; step = 4'd3;
        do_load(5, 1'b1);
        chk_st("ld_pri", 5, 1, 0, 0);
        chk("ld_pri.clip", int'(load_clip), 0);

        // step 0 hold
        step = 4'd0;
        tick();
        chk_st("s0", 5, 1, 0, 0);

        // mode 3 hold, tc forced low
        do_load(11, 1'b1);
        mode = 2'd3; dir = 1'b0; step = 4'd3;
        #1;
        chk("hold.tc", int'(tc), 0);
        tick();
        chk_st("hold", 11, 1, 0, 0);

        // oversized step clamps to window size
        do_load(2, 1'b1);
        mode = 2'd0; step = 4'd15; dir = 1'b1;
        tick();
        chk_st("bigstep", 2, 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
